// File: rtl/rc4_pkg.sv
// rc4_pkg: shared types and helpers for the RC4 multi-core key scheduler.
// Provides the default key width, the scheduler state enum and the
// key-slice offset helper used to pack per-core keys into one bus.
package rc4_pkg;
  localparam int KEY_W_DEFAULT = 22;
  typedef enum logic [2:0] {IDLE, DISPATCH, RUN, SOLVED, EXHAUSTED} sched_state_t;
  function automatic int key_lsb(input int idx, input int w);
    return idx * w;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter granting at most one requester per cycle.
// Ports: clk, reset_n (async active-low); req[N] requests; advance lets the
// priority pointer move to grant+1; grant one-hot, grant_idx its index,
// any high when some request is granted.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = N > 1 ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any
);
  logic [IW-1:0] ptr;
  // Scan from the farthest offset down so the request nearest the pointer wins.
  always_comb begin
    grant_idx = '0;
    any = 1'b0;
    for (int k = N - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % N]) begin
        grant_idx = IW'((int'(ptr) + k) % N);
        any = 1'b1;
      end
    grant = any ? N'(1) << grant_idx : '0;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) ptr <= '0;
    else if (advance && any) ptr <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
endmodule

// File: rtl/rc4_key_scheduler.sv
// rc4_key_scheduler: hands ascending candidate keys to NUM_CORES cracking cores,
// collects results round-robin, latches the first valid key and halts all cores.
// Ports: clk, reset_n (async active-low); start/abort pulses; core_done/core_valid
// from cores; core_start/core_ack pulses and packed core_key to cores; core_kill
// halts every core; busy/solved/exhausted status; found_key; keys_tried count.
module rc4_key_scheduler
  import rc4_pkg::*;
#(
  parameter int               NUM_CORES = 4,
  parameter int               KEY_W     = KEY_W_DEFAULT,
  parameter logic [KEY_W-1:0] KEY_MAX   = '1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic                       abort,
  input  logic [NUM_CORES-1:0]       core_done,
  input  logic [NUM_CORES-1:0]       core_valid,
  output logic [NUM_CORES-1:0]       core_start,
  output logic [NUM_CORES-1:0]       core_ack,
  output logic [NUM_CORES*KEY_W-1:0] core_key,
  output logic                       core_kill,
  output logic                       busy,
  output logic                       solved,
  output logic                       exhausted,
  output logic [KEY_W-1:0]           found_key,
  output logic [KEY_W:0]             keys_tried
);
  localparam int IW = NUM_CORES > 1 ? $clog2(NUM_CORES) : 1;
  localparam logic [KEY_W:0] LAST = {1'b0, KEY_MAX};
  sched_state_t state, state_n;
  logic [KEY_W:0] next_key;
  logic [IW-1:0] idx, gidx;
  logic [NUM_CORES-1:0] busy_vec, req, grant;
  logic [KEY_W-1:0] keys [NUM_CORES];
  logic gany, adv, hit, keys_left, idle_st;
  assign busy = state == DISPATCH || state == RUN;
  assign idle_st = !busy;
  assign keys_left = next_key <= LAST;
  // A core being acked this cycle still holds core_done until it sees the ack,
  // so it is masked to avoid granting the same result twice.
  assign req = core_done & busy_vec & ~core_ack;
  assign adv = state == RUN && !abort;
  assign hit = |(core_valid & grant);
  rr_arbiter #(.N(NUM_CORES)) u_arb (
    .clk(clk), .reset_n(reset_n), .req(req), .advance(adv),
    .grant(grant), .grant_idx(gidx), .any(gany)
  );
  for (genvar i = 0; i < NUM_CORES; i++) begin : g_key
    assign core_key[key_lsb(i, KEY_W) +: KEY_W] = keys[i];
  end
  always_comb begin
    state_n = state;
    if (busy && abort) state_n = IDLE;
    else if (idle_st && start) state_n = DISPATCH;
    else if (state == DISPATCH && (int'(idx) == NUM_CORES - 1 || next_key == LAST)) state_n = RUN;
    else if (state == RUN && gany && hit) state_n = SOLVED;
    else if (state == RUN && busy_vec == '0 && !keys_left) state_n = EXHAUSTED;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      core_start <= '0;
      core_ack <= '0;
      core_kill <= 1'b0;
      solved <= 1'b0;
      exhausted <= 1'b0;
      found_key <= '0;
      keys_tried <= '0;
      next_key <= '0;
      idx <= '0;
      busy_vec <= '0;
      for (int i = 0; i < NUM_CORES; i++) keys[i] <= '0;
    end else begin
      core_start <= '0;
      core_ack <= '0;
      core_kill <= 1'b0;
      if (busy && abort) begin
        core_kill <= 1'b1;
        busy_vec <= '0;
      end else if (idle_st && start) begin
        solved <= 1'b0;
        exhausted <= 1'b0;
        found_key <= '0;
        keys_tried <= '0;
        next_key <= '0;
        idx <= '0;
      end else if (state == DISPATCH) begin
        keys[idx] <= next_key[KEY_W-1:0];
        core_start[idx] <= 1'b1;
        busy_vec[idx] <= 1'b1;
        idx <= idx + 1'b1;
        next_key <= next_key + 1'b1;
      end else if (state == RUN && gany) begin
        core_ack <= grant;
        keys_tried <= keys_tried + 1'b1;
        if (hit) begin
          found_key <= keys[gidx];
          solved <= 1'b1;
          core_kill <= 1'b1;
          busy_vec <= '0;
        end else if (keys_left) begin
          keys[gidx] <= next_key[KEY_W-1:0];
          core_start[gidx] <= 1'b1;
          next_key <= next_key + 1'b1;
        end else busy_vec[gidx] <= 1'b0;
      end else if (state == RUN && busy_vec == '0 && !keys_left) exhausted <= 1'b1;
    end
endmodule

// File: tb/tb_rc4_key_scheduler.sv
// tb_rc4_key_scheduler: directed bench for rc4_key_scheduler with three DUTs
// (KEY_MAX 15, 5, 2), behavioural cores and a per-cycle key-issue model.
module tb_rc4_key_scheduler;
  localparam int LAT = 10;
  localparam int KM [3] = '{15, 5, 2};
  localparam logic [21:0] NONE = 22'h3FFFFF;
  logic clk = 1'b0, reset_n = 1'b0;
  logic [2:0] start = '0, abort = '0, auto = 3'b111;
  logic [3:0] done [3], valid [3], done_a [3], valid_a [3], done_m [3], valid_m [3];
  logic [3:0] cstart [3], cack [3];
  logic [87:0] ckey [3];
  logic ckill [3], busy [3], solved [3], exh [3], exh_p [3];
  logic [21:0] fkey [3], target [3];
  logic [22:0] tried [3];
  int tmr [3][4];
  int nchk = 0, nfail = 0, cyc = 0;
  longint exp_next [3], acks [3], kills [3], last [3][4], nstart [3][4], who [3][16];
  logic dead [3];
  always #5 clk = ~clk;
  rc4_key_scheduler #(.NUM_CORES(4), .KEY_W(22), .KEY_MAX(22'd15)) dut0 (
    .clk(clk), .reset_n(reset_n), .start(start[0]), .abort(abort[0]),
    .core_done(done[0]), .core_valid(valid[0]), .core_start(cstart[0]), .core_ack(cack[0]),
    .core_key(ckey[0]), .core_kill(ckill[0]), .busy(busy[0]), .solved(solved[0]),
    .exhausted(exh[0]), .found_key(fkey[0]), .keys_tried(tried[0]));
  rc4_key_scheduler #(.NUM_CORES(4), .KEY_W(22), .KEY_MAX(22'd5)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start[1]), .abort(abort[1]),
    .core_done(done[1]), .core_valid(valid[1]), .core_start(cstart[1]), .core_ack(cack[1]),
    .core_key(ckey[1]), .core_kill(ckill[1]), .busy(busy[1]), .solved(solved[1]),
    .exhausted(exh[1]), .found_key(fkey[1]), .keys_tried(tried[1]));
  rc4_key_scheduler #(.NUM_CORES(4), .KEY_W(22), .KEY_MAX(22'd2)) dut2 (
    .clk(clk), .reset_n(reset_n), .start(start[2]), .abort(abort[2]),
    .core_done(done[2]), .core_valid(valid[2]), .core_start(cstart[2]), .core_ack(cack[2]),
    .core_key(ckey[2]), .core_kill(ckill[2]), .busy(busy[2]), .solved(solved[2]),
    .exhausted(exh[2]), .found_key(fkey[2]), .keys_tried(tried[2]));
  always_comb
    for (int u = 0; u < 3; u++) begin
      done[u] = auto[u] ? done_a[u] : done_m[u];
      valid[u] = auto[u] ? valid_a[u] : valid_m[u];
    end
  // Behavioural cores: finish LAT cycles after core_start, valid only for the target key.
  always @(posedge clk)
    for (int u = 0; u < 3; u++)
      for (int i = 0; i < 4; i++)
        if (!reset_n || ckill[u]) begin
          done_a[u][i] <= 1'b0;
          valid_a[u][i] <= 1'b0;
          tmr[u][i] <= 0;
        end else begin
          if (cack[u][i]) done_a[u][i] <= 1'b0;
          if (cstart[u][i]) begin
            tmr[u][i] <= LAT;
            valid_a[u][i] <= ckey[u][i*22 +: 22] == target[u];
          end else if (tmr[u][i] == 1) begin
            tmr[u][i] <= 0;
            done_a[u][i] <= 1'b1;
          end else if (tmr[u][i] > 0) tmr[u][i] <= tmr[u][i] - 1;
        end
  task automatic chk(input string nm, input longint act, input longint exp);
    nchk++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask
  function automatic int oh(input logic [3:0] v);
    for (int k = 0; k < 4; k++) if (v[k]) return k;
    return 0;
  endfunction
  // Model: keys leave in strict ascending order from 0, never beyond KEY_MAX,
  // never after a kill; every ack consumes a pending result and bumps keys_tried.
  task automatic monitor();
    forever begin
      @(negedge clk);
      cyc++;
      for (int u = 0; u < 3; u++) begin
        if (!reset_n || start[u]) begin
          exp_next[u] = 0; acks[u] = 0; kills[u] = 0; dead[u] = 1'b0;
          for (int i = 0; i < 4; i++) nstart[u][i] = 0;
          for (int k = 0; k < 16; k++) who[u][k] = -1;
        end else begin
          for (int i = 0; i < 4; i++)
            if (cack[u][i]) begin
              acks[u]++;
              chk("ack_pending_done", done[u][i], 1);
              chk("ack_solved", solved[u], longint'(auto[u] && last[u][i] == target[u]));
              if (auto[u] && last[u][i] == target[u]) begin
                chk("ack_found_key", fkey[u], last[u][i]);
                chk("ack_kill", ckill[u], 1);
              end
            end
          if (cack[u] != 0) chk("keys_tried", tried[u], acks[u]);
          for (int i = 0; i < 4; i++)
            if (cstart[u][i]) begin
              chk("issue_order", ckey[u][i*22 +: 22], exp_next[u]);
              chk("issue_range", longint'(exp_next[u] <= KM[u]), 1);
              chk("start_after_kill", dead[u], 0);
              last[u][i] = exp_next[u];
              if (exp_next[u] < 16) who[u][exp_next[u]] = i;
              nstart[u][i]++;
              exp_next[u]++;
            end
          if (ckill[u]) begin kills[u]++; dead[u] = 1'b1; end
          if (exh[u] && !exh_p[u]) chk("exh_all_issued", exp_next[u], KM[u] + 1);
        end
        exh_p[u] = exh[u];
      end
    end
  endtask
  task automatic pulse_start(input logic [2:0] m);
    @(posedge clk); #1 start = m;
    @(posedge clk); #1 start = '0;
  endtask
  // Raise done on the cores in m (DUT 0, manual mode) and record ack order.
  task automatic collect(input logic [3:0] m, output logic [7:0] ord, output int span);
    int c0, g;
    ord = '0; span = 0; c0 = 0;
    done_m[0] = done_m[0] | m;
    for (int n = 0; n < $countones(m); n++) begin
      @(negedge clk);
      for (int k = 0; k < 10 && cack[0] == 0; k++) @(negedge clk);
      if (cack[0] == 0) chk("ack_timeout", 0, 1);
      g = oh(cack[0]);
      ord[2*n +: 2] = 2'(g);
      if (n == 0) c0 = cyc;
      span = cyc - c0;
      @(posedge clk); #1 done_m[0][g] = 1'b0;
    end
  endtask
  initial begin
    logic [7:0] ord;
    int span;
    for (int u = 0; u < 3; u++) begin
      done_m[u] = '0; valid_m[u] = '0; target[u] = NONE; exh_p[u] = 1'b0;
    end
    fork monitor(); join_none
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", busy[0], 0);
    chk("rst_solved", solved[0], 0);
    chk("rst_exh", exh[0], 0);
    chk("rst_core_start", cstart[0], 0);
    chk("rst_core_key", longint'(ckey[0] == '0), 1);
    chk("rst_keys_tried", tried[0], 0);
    // Arbitration order with manual cores.
    auto[0] = 1'b0;
    pulse_start(3'b001);
    repeat (8) @(posedge clk);
    #1;
    collect(4'hF, ord, span);
    chk("rr_order_ptr0", ord, 8'hE4);
    chk("rr_consecutive0", span, 3);
    collect(4'b0001, ord, span);
    chk("rr_single0", ord[1:0], 0);
    collect(4'b0010, ord, span);
    chk("rr_single1", ord[1:0], 1);
    collect(4'hF, ord, span);
    chk("rr_order_ptr2", ord, 8'h4E);
    chk("rr_consecutive2", span, 3);
    // Abort races a valid result.
    done_m[0][2] = 1'b1; valid_m[0][2] = 1'b1; abort = 3'b001;
    @(posedge clk); #1 abort = '0; done_m[0] = '0; valid_m[0] = '0;
    @(negedge clk);
    chk("abort_kill", ckill[0], 1);
    chk("abort_busy", busy[0], 0);
    chk("abort_solved", solved[0], 0);
    chk("abort_found_key", fkey[0], 0);
    chk("abort_no_ack", cack[0], 0);
    repeat (3) @(negedge clk);
    chk("abort_kill_once", kills[0], 1);
    chk("abort_stays_idle", busy[0], 0);
    // Asynchronous reset mid-run.
    auto[0] = 1'b1; target[0] = 22'd11;
    pulse_start(3'b001);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("midrun_busy", busy[0], 1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_busy", busy[0], 0);
    chk("arst_core_key", longint'(ckey[0] == '0), 1);
    chk("arst_pulses", longint'({cstart[0], cack[0], ckill[0]}), 0);
    chk("arst_status", longint'({solved[0], exh[0]}), 0);
    chk("arst_found_tried", longint'({fkey[0], tried[0]}), 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    // Full searches: DUT0 solves at key 11, DUT1/DUT2 exhaust.
    pulse_start(3'b111);
    @(negedge clk);
    for (int k = 0; k < 10 && cstart[0] == 0; k++) @(negedge clk);
    chk("first_start_core0", cstart[0], 4'b0001);
    chk("first_key0", ckey[0][21:0], 0);
    for (int k = 0; k < 400 && !solved[0]; k++) @(negedge clk);
    chk("solve_solved", solved[0], 1);
    chk("solve_found_key", fkey[0], 22'h00B);
    for (int k = 0; k < 400 && !(exh[1] && exh[2]); k++) @(negedge clk);
    repeat (10) @(negedge clk);
    chk("solve_kill_once", kills[0], 1);
    chk("solve_tried_range", longint'(tried[0] >= 12 && tried[0] <= 16), 1);
    chk("solve_busy", busy[0], 0);
    chk("solve_no_exh", exh[0], 0);
    chk("km5_exhausted", exh[1], 1);
    chk("km5_tried", tried[1], 6);
    chk("km5_busy", busy[1], 0);
    chk("km5_solved", solved[1], 0);
    chk("km5_key4_core", who[1][4], 0);
    chk("km5_key5_core", who[1][5], 1);
    chk("km5_no_key6", exp_next[1], 6);
    chk("km2_exhausted", exh[2], 1);
    chk("km2_tried", tried[2], 3);
    chk("km2_busy", busy[2], 0);
    chk("km2_starts", longint'({nstart[2][0], nstart[2][1], nstart[2][2], nstart[2][3]} == {64'd1, 64'd1, 64'd1, 64'd0}), 1);
    chk("km2_key_owner", longint'({who[2][0], who[2][1], who[2][2]} == {64'd0, 64'd1, 64'd2}), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule

// File: doc/rc4_key_scheduler.md
Name: rc4_key_scheduler

Overview:
Multi-core brute-force controller for the RC4 cracking datapath. Hands out 22-bit candidate keys, in ascending order, to NUM_CORES independent init/shuffle/decrypt cores. Collects each core's done/valid result through a round-robin arbiter. On the first valid result it latches the key and halts every core; it flags exhaustion when the keyspace runs out. Sits between the top level (switches, LEDs, HEX) and the replicated cracking cores, and replaces the single-core sweep counter.

Parameters:
NUM_CORES, 4, number of cracking cores driven (1..8)
KEY_W, 22, candidate key width
KEY_MAX, 22'h3FFFFF, last candidate key searched (inclusive)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a search from key 0
abort  in  1  one-cycle pulse; stops the search
core_done  in  NUM_CORES  per-core result ready; held high until core_ack
core_valid  in  NUM_CORES  per-core plaintext-valid; qualified by core_done
core_start  out  NUM_CORES  one-cycle pulse; core begins on core_key slice
core_ack  out  NUM_CORES  one-cycle pulse; result consumed
core_key  out  NUM_CORES*KEY_W  per-core key; slice i = bits [i*KEY_W +: KEY_W]; stable while core busy
core_kill  out  1  one-cycle pulse; synchronous reset of all cores
busy  out  1  search in progress
solved  out  1  sticky; valid key found
exhausted  out  1  sticky; all keys tried, none valid
found_key  out  KEY_W  key reported valid
keys_tried  out  KEY_W+1  count of acknowledged results

Behaviour:
- Reset: all outputs and all internal registers go to 0 asynchronously. State returns to IDLE. RR pointer returns to 0.
- States are IDLE, DISPATCH, RUN, SOLVED, EXHAUSTED.
- IDLE, SOLVED, EXHAUSTED:
  - start: clear solved, exhausted, found_key and keys_tried; set next_key=0 and dispatch index=0; go to DISPATCH.
  - start while busy is ignored.
- DISPATCH:
  - Each cycle, load core_key[idx]=next_key, pulse core_start[idx], set busy_vec[idx], then idx++ and next_key++.
  - Go to RUN after idx reaches NUM_CORES, or once next_key exceeds KEY_MAX (cores above that index are never started).
  - core_done is not serviced in DISPATCH.
- RUN:
  - The arbiter grants at most one core per cycle. Requests are core_done & busy_vec.
  - Search starts at the RR pointer; the pointer advances to grant+1 mod NUM_CORES after each grant.
  - On a grant g, core_ack[g] pulses on the next edge.
  - If core_valid[g]=1: found_key<=core_key[g], solved<=1, core_kill pulses, busy_vec<=0, go to SOLVED.
  - Else, if next_key<=KEY_MAX: core_key[g]<=next_key, core_start[g] pulses in the same cycle as core_ack[g], next_key++.
  - Else: clear busy_vec[g].
  - When busy_vec==0 and next_key>KEY_MAX: exhausted<=1, go to EXHAUSTED.
- keys_tried increments on every grant, including the valid grant.
- next_key is KEY_W+1 bits wide, so KEY_MAX=all-ones terminates without wrapping. Keys are never re-issued.
- busy=1 in DISPATCH and RUN only.
- Simultaneous events:
  - abort beats start and any same-cycle valid grant: core_kill pulses, busy_vec clears, state goes to IDLE, solved stays 0.
  - abort in IDLE, SOLVED or EXHAUSTED is ignored.
  - Ungranted done cores stay pending; core_done must be held by the core until acked.
- Latency:
  - done to ack is 1 cycle when uncontended.
  - Worst case is NUM_CORES cycles.
  - Valid done to solved/core_kill is 1 cycle.

Decomposition:
- Shared package rc4_pkg holds:
  - KEY_W localparam default
  - sched_state_t enum (IDLE, DISPATCH, RUN, SOLVED, EXHAUSTED)
  - helper function for the key-slice index
- Sub-module rr_arbiter (parameter N):
  - inputs: req[N], advance
  - outputs: one-hot grant[N], grant_idx, any
  - rotating priority pointer, updated only on advance

Test Plan:
1. NUM_CORES=4, KEY_MAX=15, cores done 10 cycles after start, valid only for key 0x00B -> solved=1, found_key=0x00B, exactly one core_kill pulse, no core_start after it, keys_tried<=16.
2. KEY_MAX=5, never valid -> keys 4 and 5 go to the first two finishers, key 6 is never issued, exhausted=1, keys_tried=6, busy=0.
3. All 4 cores raise done in the same cycle with pointer 0 -> core_ack order 0,1,2,3 on consecutive cycles. Repeat with pointer at 2 -> order 2,3,0,1.
4. abort in the same cycle as a core_done+core_valid -> state IDLE, solved=0, core_kill one pulse, found_key unchanged (0).
5. reset_n low mid-RUN -> all outputs 0 with no clock edge. After release, start -> core_start[0] with core_key slice 0 = 0.
6. KEY_MAX=2, NUM_CORES=4 -> only cores 0-2 started with keys 0,1,2. Core 3 never started. exhausted after 3 acks.
